ex_wb_seq: RTL

//  Writeback sequencer directly downstream of the ALU. Registers each ALU result and drives the single

---
 rtl/ex_wb_if.sv | 34 +++
 rtl/ex_wb_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/ex_wb_if.sv
// Bundle of the ALU-to-writeback handshake, register-file write port and exception signals.
// The master side is the upstream/control environment; the slave side is the sequencer.
interface ex_wb_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2*DATA_W-1:0] alu_rslt;
    logic [DATA_W-1:0]   alu_rslt_r15;
    logic                ov_excep;
    logic [1:0]          muldiv_op;
    logic                reg_write;
    logic [REG_AW-1:0]   dest_reg;
    logic [DATA_W-1:0]   pc;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                excep;
    logic                excep_ack;
    logic [DATA_W-1:0]   epc;

    modport master (
        output in_valid, alu_rslt, alu_rslt_r15, ov_excep, muldiv_op,
               reg_write, dest_reg, pc, excep_ack,
        input  in_ready, rf_we, rf_waddr, rf_wdata, excep, epc
    );

    modport slave (
        input  in_valid, alu_rslt, alu_rslt_r15, ov_excep, muldiv_op,
               reg_write, dest_reg, pc, excep_ack,
        output in_ready, rf_we, rf_waddr, rf_wdata, excep, epc
    );
endinterface

// File: rtl/ex_wb_seq.sv
// Writeback sequencer: registers ALU results onto the single register-file write port,
// splits mul/div into a primary write plus an R15 write, and latches overflow exceptions.
module ex_wb_seq #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int R15_ADDR = 15
) (
    input  logic   clk,
    input  logic   rst_n,
    ex_wb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WR, R15, EXC} state_t;

    state_t              state_q, state_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                excep_q, excep_d;
    logic [DATA_W-1:0]   epc_q, epc_d;
    logic                md_q, md_d;
    logic [DATA_W-1:0]   r15_q, r15_d;

    logic                in_ready;
    logic                xfer;
    logic                in_is_md;
    logic [DATA_W-1:0]   sel_data;

    // Upstream stalls while the exception is pending and during the first half of a mul/div.
    assign in_ready = (state_q != EXC) && !((state_q == WR) && md_q);
    assign xfer     = bus.in_valid && in_ready;
    assign in_is_md = (bus.muldiv_op == 2'b01) || (bus.muldiv_op == 2'b10);

    always_comb begin
        sel_data = bus.alu_rslt[DATA_W-1:0];
        if (bus.muldiv_op == 2'b10)
            sel_data = bus.alu_rslt[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        excep_d    = excep_q;
        epc_d      = epc_q;
        md_d       = md_q;
        r15_d      = r15_q;

        if (state_q == EXC) begin
            if (bus.excep_ack) begin
                state_d = IDLE;
                excep_d = 1'b0;
            end
        end else if ((state_q == WR) && md_q) begin
            state_d    = R15;
            rf_we_d    = 1'b1;
            rf_waddr_d = REG_AW'(R15_ADDR);
            rf_wdata_d = r15_q;
        end else if (xfer) begin
            // Overflow takes precedence over any mul/div second write.
            if (bus.ov_excep) begin
                state_d = EXC;
                excep_d = 1'b1;
                epc_d   = bus.pc;
                md_d    = 1'b0;
            end else begin
                state_d    = WR;
                rf_we_d    = bus.reg_write;
                rf_waddr_d = bus.dest_reg;
                rf_wdata_d = sel_data;
                md_d       = in_is_md;
                r15_d      = bus.alu_rslt_r15;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            excep_q    <= 1'b0;
            epc_q      <= '0;
            md_q       <= 1'b0;
            r15_q      <= '0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            excep_q    <= excep_d;
            epc_q      <= epc_d;
            md_q       <= md_d;
            r15_q      <= r15_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.excep    = excep_q;
    assign bus.epc      = epc_q;
endmodule
